expr_sequencer: RTL

- Moore FSM that drives the select of the shared 4:1 16-bit signed operand mux, one operand per cycle.
- Accumulates the mux output to evaluate result = ((a + b) * c) - d.
- Sits between the top-level start/done interface and the operand mux. Operands a..d stay on the mux inputs; the sequencer sees only mux_out.
- Provides a start/busy/done handshake, a registered result and a sticky overflow flag.

---
 rtl/expr_sequencer.sv | 88 ++++++++
 1 files changed

// File: rtl/expr_sequencer.sv
// expr_sequencer: Moore sequencer that steps the operand mux select through a..d
// and accumulates mux_out to evaluate ((a + b) * c) - d with a sticky overflow flag.
module expr_sequencer #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] mux_out,
    output logic [1:0]       select,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             overflow
);
    typedef enum logic [2:0] {IDLE, LD_A, ADD_B, MUL_C, SUB_D, DONE} state_t;
    state_t state;
    logic [WIDTH-1:0] acc;
    logic [WIDTH:0] sum, dif;
    logic [2*WIDTH-1:0] acc_x, mux_x, prod;
    logic sum_ovf, dif_ovf, prod_ovf;
    // One guard bit detects add/sub overflow; the product is checked by sign-extension of its top half
    assign sum = {acc[WIDTH-1], acc} + {mux_out[WIDTH-1], mux_out};
    assign dif = {acc[WIDTH-1], acc} - {mux_out[WIDTH-1], mux_out};
    assign acc_x = {{WIDTH{acc[WIDTH-1]}}, acc};
    assign mux_x = {{WIDTH{mux_out[WIDTH-1]}}, mux_out};
    assign prod = acc_x * mux_x;
    assign sum_ovf = sum[WIDTH] ^ sum[WIDTH-1];
    assign dif_ovf = dif[WIDTH] ^ dif[WIDTH-1];
    assign prod_ovf = !((&prod[2*WIDTH-1:WIDTH-1]) | ~(|prod[2*WIDTH-1:WIDTH-1]));
    // Outputs are registered with the values belonging to the state being entered
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            acc <= '0;
            result <= '0;
            overflow <= 1'b0;
            select <= 2'b00;
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    state <= LD_A;
                    overflow <= 1'b0;
                    select <= 2'b00;
                    busy <= 1'b1;
                end
                LD_A: begin
                    acc <= mux_out;
                    state <= ADD_B;
                    select <= 2'b01;
                end
                ADD_B: begin
                    acc <= sum[WIDTH-1:0];
                    overflow <= overflow | sum_ovf;
                    state <= MUL_C;
                    select <= 2'b10;
                end
                MUL_C: begin
                    acc <= prod[WIDTH-1:0];
                    overflow <= overflow | prod_ovf;
                    state <= SUB_D;
                    select <= 2'b11;
                end
                SUB_D: begin
                    acc <= dif[WIDTH-1:0];
                    result <= dif[WIDTH-1:0];
                    overflow <= overflow | dif_ovf;
                    state <= DONE;
                    select <= 2'b00;
                    busy <= 1'b0;
                    done <= 1'b1;
                end
                DONE: begin
                    state <= IDLE;
                    done <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    select <= 2'b00;
                    busy <= 1'b0;
                    done <= 1'b0;
                end
            endcase
        end
    end
endmodule
